// File: rtl/detonator_seq_ctrl_if.sv
// Keypad, control and status bundle of the detonator sequencing controller.
// master: the side that drives keypad/controls (top level or bench).
// slave:  the sequencing controller itself.
interface detonator_seq_ctrl_if;
   logic [9:0] A;        // one-hot keypad, bit k = digit k
   logic       setup;    // program a new code
   logic       ready;    // start code entry
   logic       sure;     // confirm entered digits
   logic       fire;     // start countdown
   logic       wait_t;   // abort to idle
   logic [3:0] m_disp;   // display nibble
   logic       lt;       // armed lamp
   logic       bt;       // blast output
   logic       rt;       // error lamp
   logic       lb;       // lockout lamp

   modport master (
      output A, setup, ready, sure, fire, wait_t,
      input  m_disp, lt, bt, rt, lb
   );

   modport slave (
      input  A, setup, ready, sure, fire, wait_t,
      output m_disp, lt, bt, rt, lb
   );
endinterface

// File: rtl/detonator_seq_ctrl.sv
// Sequencing controller for the numeric code detonator: keypad edge detect,
// code entry/programming, compare, arm, countdown, blast, error, lockout.
// Optional feature macro: DETONATOR_LOCKOUT_EN enables the wrong-try counter
// and the LOCK state; without it every mismatch goes to ERROR and lb is 0.
module detonator_seq_ctrl #(
   parameter int          CODE_LEN    = 4,
   parameter int          COUNTDOWN   = 8,
   parameter int          ERR_CYCLES  = 4,
   parameter int          MAX_TRIES   = 3,
   parameter int          LOCK_CYCLES = 16,
   parameter logic [31:0] RST_CODE    = 32'h0000_2580
) (
   input logic                 clk,
   input logic                 rst,
   detonator_seq_ctrl_if.slave bus
);

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   localparam int CW   = 4 * CODE_LEN;
   // One width for every down-counter and the try counter; at least 4 bits
   // so the countdown value can be shown directly on the display.
   localparam int TMAX = max2(max2(15, MAX_TRIES),
                              max2(max2(COUNTDOWN, ERR_CYCLES), LOCK_CYCLES));
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_ENTRY,
      S_ARMED,
      S_COUNT,
      S_BLAST,
      S_ERROR
`ifdef DETONATOR_LOCKOUT_EN
      , S_LOCK
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   code_q, code_d;
   logic [CW-1:0]   buf_q, buf_d;
   logic [CW-1:0]   buf_shift;
   logic [3:0]      cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [9:0]      a_q;
   logic [3:0]      m_disp_q, m_disp_d;
   logic            lt_q, lt_d, bt_q, bt_d, rt_q, rt_d, lb_q, lb_d;
   logic            press;
   logic [3:0]      digit;
   logic            code_match;
`ifdef DETONATOR_LOCKOUT_EN
   logic [TW-1:0]   tries_q, tries_d;
   logic [TW-1:0]   tries_inc;
`endif

   // Newest digit enters at the bottom of the entry buffer.
   generate
      if (CODE_LEN == 1) begin : g_shift_one
         assign buf_shift = digit;
      end else begin : g_shift_many
         assign buf_shift = {buf_q[CW-5:0], digit};
      end
   endgenerate

   // Keypad rising-edge detect: single key, previously all released.
   always_comb begin
      digit = 4'h0;
      for (int k = 0; k < 10; k++) begin
         if (bus.A[k]) digit = 4'(k);
      end
      press = $onehot(bus.A) && (a_q == 10'd0);
   end

   assign code_match = (cnt_q == 4'(CODE_LEN)) && (buf_q == code_q);
`ifdef DETONATOR_LOCKOUT_EN
   assign tries_inc = tries_q + TW'(1);
`endif

   // Next-state logic; wait_t beats sure beats press inside each state.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
`ifdef DETONATOR_LOCKOUT_EN
      tries_d = tries_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.setup) begin
               state_d = S_SET;
               buf_d   = '0;
               cnt_d   = 4'd0;
            end else if (bus.ready) begin
               state_d = S_ENTRY;
               buf_d   = '0;
               cnt_d   = 4'd0;
            end
         end
         S_SET: begin
            if (bus.wait_t) begin
               state_d = S_IDLE;
            end else if (bus.sure) begin
               // a short entry is ignored and SET keeps collecting
               if (cnt_q == 4'(CODE_LEN)) begin
                  code_d  = buf_q;
                  state_d = S_IDLE;
               end
            end else if (press && (cnt_q < 4'(CODE_LEN))) begin
               buf_d = buf_shift;
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ENTRY: begin
            if (bus.wait_t) begin
               state_d = S_IDLE;
            end else if (bus.sure) begin
               if (code_match) begin
                  state_d = S_ARMED;
`ifdef DETONATOR_LOCKOUT_EN
                  tries_d = '0;
`endif
               end else begin
`ifdef DETONATOR_LOCKOUT_EN
                  tries_d = tries_inc;
                  if (tries_inc == TW'(MAX_TRIES)) begin
                     state_d = S_LOCK;
                     timer_d = TW'(LOCK_CYCLES);
                  end else begin
                     state_d = S_ERROR;
                     timer_d = TW'(ERR_CYCLES);
                  end
`else
                  state_d = S_ERROR;
                  timer_d = TW'(ERR_CYCLES);
`endif
               end
            end else if (press && (cnt_q < 4'(CODE_LEN))) begin
               buf_d = buf_shift;
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ARMED: begin
            if (bus.wait_t) begin
               state_d = S_IDLE;
            end else if (bus.fire) begin
               state_d = S_COUNT;
               timer_d = TW'(COUNTDOWN);
            end
         end
         S_COUNT: begin
            if (bus.wait_t) begin
               state_d = S_IDLE;
            end else if (timer_q == TW'(1)) begin
               state_d = S_BLAST;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_BLAST: begin
            state_d = S_BLAST;
         end
         S_ERROR: begin
            if (timer_q == TW'(1)) state_d = S_IDLE;
            else                   timer_d = timer_q - TW'(1);
         end
`ifdef DETONATOR_LOCKOUT_EN
         S_LOCK: begin
            if (timer_q == TW'(1)) begin
               state_d = S_IDLE;
               tries_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      m_disp_d = 4'hF;
      lt_d     = 1'b0;
      bt_d     = 1'b0;
      rt_d     = 1'b0;
      lb_d     = 1'b0;
      case (state_d)
         S_IDLE:  m_disp_d = 4'hF;
         S_SET,
         S_ENTRY: m_disp_d = (cnt_d == 4'd0) ? 4'hF : buf_d[3:0];
         S_ARMED: begin
            m_disp_d = 4'hA;
            lt_d     = 1'b1;
         end
         S_COUNT: begin
            m_disp_d = timer_d[3:0];
            lt_d     = 1'b1;
         end
         S_BLAST: begin
            m_disp_d = 4'h0;
            bt_d     = 1'b1;
         end
         S_ERROR: begin
            m_disp_d = 4'hE;
            rt_d     = 1'b1;
         end
`ifdef DETONATOR_LOCKOUT_EN
         S_LOCK: begin
            m_disp_d = 4'hC;
            lb_d     = 1'b1;
         end
`endif
         default: m_disp_d = 4'hF;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         code_q   <= RST_CODE[CW-1:0];
         buf_q    <= '0;
         cnt_q    <= 4'd0;
         timer_q  <= '0;
         a_q      <= 10'd0;
         m_disp_q <= 4'hF;
         lt_q     <= 1'b0;
         bt_q     <= 1'b0;
         rt_q     <= 1'b0;
         lb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         a_q      <= bus.A;
         m_disp_q <= m_disp_d;
         lt_q     <= lt_d;
         bt_q     <= bt_d;
         rt_q     <= rt_d;
         lb_q     <= lb_d;
      end
   end

`ifdef DETONATOR_LOCKOUT_EN
   // Consecutive wrong-code counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tries_q <= '0;
      else     tries_q <= tries_d;
   end
`endif

   assign bus.m_disp = m_disp_q;
   assign bus.lt     = lt_q;
   assign bus.bt     = bt_q;
   assign bus.rt     = rt_q;
   assign bus.lb     = lb_q;

endmodule

// File: tb/tb_detonator_seq_ctrl.sv
// Self-checking bench for detonator_seq_ctrl: table of per-cycle vectors
// plus a hand-written mid-countdown reset sequence. Honors
// DETONATOR_LOCKOUT_EN for the lockout expectations.
module tb_detonator_seq_ctrl;

   localparam logic [4:0] C_NONE  = 5'b00000;
   localparam logic [4:0] C_SETUP = 5'b10000;
   localparam logic [4:0] C_READY = 5'b01000;
   localparam logic [4:0] C_SURE  = 5'b00100;
   localparam logic [4:0] C_FIRE  = 5'b00010;
   localparam logic [4:0] C_WAIT  = 5'b00001;

   // lamps packed as {lt, bt, rt, lb}
   localparam logic [3:0] L_NONE = 4'b0000;
   localparam logic [3:0] L_LT   = 4'b1000;
   localparam logic [3:0] L_BT   = 4'b0100;
   localparam logic [3:0] L_RT   = 4'b0010;
   localparam logic [3:0] L_LB   = 4'b0001;

   typedef struct {
      logic [9:0] a;
      logic [4:0] ctl;
      logic       rst_first;
      logic [3:0] disp;
      logic [3:0] lamps;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   next_rst = 1'b0;
   vec_t vq[$];

   detonator_seq_ctrl_if bus();

   detonator_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int id,
                        input logic [3:0] ed, input logic [3:0] el);
      logic [3:0] al;
      al = {bus.lt, bus.bt, bus.rt, bus.lb};
      checks++;
      if (bus.m_disp !== ed || al !== el) begin
         errors++;
         $display("FAIL %s %0d: m_disp=%h lamps(lt,bt,rt,lb)=%b required m_disp=%h lamps=%b",
                  nm, id, bus.m_disp, al, ed, el);
      end else begin
         $display("ok   %s %0d: m_disp=%h lamps=%b", nm, id, bus.m_disp, al);
      end
   endtask

   task automatic drive(input logic [9:0] a, input logic [4:0] ctl);
      bus.A = a;
      {bus.setup, bus.ready, bus.sure, bus.fire, bus.wait_t} = ctl;
   endtask

   // One clock: drive on the falling edge, check just after the rising edge.
   task automatic step(input logic [9:0] a, input logic [4:0] ctl,
                       input logic [3:0] ed, input logic [3:0] el,
                       input string nm, input int id);
      @(negedge clk);
      drive(a, ctl);
      @(posedge clk);
      #1;
      check(nm, id, ed, el);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
   task automatic pulse_rst_check(input int id);
      @(negedge clk);
      drive(10'd0, C_NONE);
      #1 rst = 1'b1;
      #1 check("reset", id, 4'hF, L_NONE);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic add(input logic [9:0] a, input logic [4:0] ctl,
                      input logic [3:0] d, input logic [3:0] l);
      vec_t v;
      v.a         = a;
      v.ctl       = ctl;
      v.rst_first = next_rst;
      v.disp      = d;
      v.lamps     = l;
      vq.push_back(v);
      next_rst = 1'b0;
   endtask

   task automatic add_key(input int k);
      add(10'(1 << k), C_NONE, 4'(k), L_NONE);
      add(10'd0,       C_NONE, 4'(k), L_NONE);
   endtask

   task automatic add_code(input int d0, input int d1, input int d2, input int d3);
      add_key(d0);
      add_key(d1);
      add_key(d2);
      add_key(d3);
   endtask

   task automatic add_hold(input int n, input logic [4:0] ctl,
                           input logic [3:0] d, input logic [3:0] l);
      for (int i = 0; i < n; i++) add(10'd0, ctl, d, l);
   endtask

   // ready, code, sure -> ERROR for 4 cycles, then IDLE
   task automatic add_wrong_entry();
      add(10'd0, C_READY, 4'hF, L_NONE);
      add_code(2, 5, 8, 1);
      add(10'd0, C_SURE, 4'hE, L_RT);
      add_hold(3, C_NONE, 4'hE, L_RT);
      add(10'd0, C_NONE, 4'hF, L_NONE);
   endtask

   task automatic add_right_entry(input int d0, input int d1, input int d2, input int d3);
      add(10'd0, C_READY, 4'hF, L_NONE);
      add_code(d0, d1, d2, d3);
      add(10'd0, C_SURE, 4'hA, L_LT);
   endtask

   initial begin
      int digs[4];
      drive(10'd0, C_NONE);

      // Correct code, countdown, terminal blast.
      next_rst = 1'b1;
      add_right_entry(2, 5, 8, 0);
      add(10'd0, C_FIRE, 4'h8, L_LT);
      for (int t = 7; t >= 1; t--) add(10'd0, C_NONE, 4'(t), L_LT);
      add(10'd0, C_NONE,  4'h0, L_BT);
      add(10'd0, C_NONE,  4'h0, L_BT);
      add(10'd0, C_READY, 4'h0, L_BT);
      add(10'd0, C_WAIT,  4'h0, L_BT);

      // Reset out of BLAST, then wrong code; fire afterwards does nothing.
      next_rst = 1'b1;
      add_wrong_entry();
      add(10'd0, C_FIRE, 4'hF, L_NONE);

      // Edge handling: held key counts once, multi-key pattern ignored.
      add(10'd0, C_READY, 4'hF, L_NONE);
      add(10'd1 << 5, C_NONE, 4'h5, L_NONE);
      add(10'd1 << 5, C_NONE, 4'h5, L_NONE);
      add(10'd1 << 5, C_NONE, 4'h5, L_NONE);
      add(10'b00_0101_0000, C_NONE, 4'h5, L_NONE);
      add(10'd0, C_NONE, 4'h5, L_NONE);
      add(10'd0, C_WAIT, 4'hF, L_NONE);

      // Reprogram: short SET entry ignored, then 1337 replaces 2580.
      next_rst = 1'b1;
      add(10'd0, C_SETUP, 4'hF, L_NONE);
      add_key(1);
      add_key(3);
      add_key(3);
      add(10'd0, C_SURE, 4'h3, L_NONE);
      add(10'd0, C_WAIT, 4'hF, L_NONE);
      add_right_entry(2, 5, 8, 0);
      add(10'd0, C_WAIT, 4'hF, L_NONE);
      add(10'd0, C_SETUP, 4'hF, L_NONE);
      add_code(1, 3, 3, 7);
      add(10'd0, C_SURE, 4'hF, L_NONE);
      add(10'd0, C_READY, 4'hF, L_NONE);
      add_code(2, 5, 8, 0);
      add(10'd0, C_SURE, 4'hE, L_RT);
      add_hold(3, C_NONE, 4'hE, L_RT);
      add(10'd0, C_NONE, 4'hF, L_NONE);
      add_right_entry(1, 3, 3, 7);
      // Abort at countdown value 3.
      add(10'd0, C_FIRE, 4'h8, L_LT);
      for (int t = 7; t >= 3; t--) add(10'd0, C_NONE, 4'(t), L_LT);
      add(10'd0, C_WAIT, 4'hF, L_NONE);
      add_hold(8, C_NONE, 4'hF, L_NONE);

      // Three wrong codes; reset has restored 2580.
      next_rst = 1'b1;
      add_wrong_entry();
      add_wrong_entry();
      add(10'd0, C_READY, 4'hF, L_NONE);
      add_code(2, 5, 8, 1);
`ifdef DETONATOR_LOCKOUT_EN
      add(10'd0, C_SURE, 4'hC, L_LB);
      for (int i = 0; i < 15; i++)
         add(10'd0, (i % 2 == 0) ? C_READY : C_WAIT, 4'hC, L_LB);
      add(10'd0, C_NONE, 4'hF, L_NONE);
`else
      add(10'd0, C_SURE, 4'hE, L_RT);
      add_hold(3, C_NONE, 4'hE, L_RT);
      add(10'd0, C_NONE, 4'hF, L_NONE);
`endif
      add_right_entry(2, 5, 8, 0);

      // Power-on reset.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].rst_first) pulse_rst_check(i);
         step(vq[i].a, vq[i].ctl, vq[i].disp, vq[i].lamps, "vec", i);
      end

      // Reset in the middle of a countdown.
      digs = '{2, 5, 8, 0};
      pulse_rst_check(1000);
      step(10'd0, C_READY, 4'hF, L_NONE, "cdrst", 0);
      for (int i = 0; i < 4; i++) begin
         step(10'(1 << digs[i]), C_NONE, 4'(digs[i]), L_NONE, "cdrst", 1 + 2 * i);
         step(10'd0, C_NONE, 4'(digs[i]), L_NONE, "cdrst", 2 + 2 * i);
      end
      step(10'd0, C_SURE, 4'hA, L_LT, "cdrst", 9);
      step(10'd0, C_FIRE, 4'h8, L_LT, "cdrst", 10);
      step(10'd0, C_NONE, 4'h7, L_LT, "cdrst", 11);
      step(10'd0, C_NONE, 4'h6, L_LT, "cdrst", 12);
      pulse_rst_check(1001);
      for (int i = 0; i < 10; i++)
         step(10'd0, C_NONE, 4'hF, L_NONE, "cdrst", 13 + i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
